ram: RTL and testbench

- 16-word x 16-bit register-based main memory for the 16-bit SAP computer.
- Takes write data from the shared 16-bit system bus.
- Address comes from the memory address register.
- Read data is presented continuously on a dedicated output, which the bus-drive logic gates onto the bus.
- Reads are combinational; writes are synchronous.

---
 rtl/sap_pkg.sv | 14 +
 rtl/ram_if.sv | 25 ++
 rtl/ram_word_reg.sv | 29 ++
 rtl/ram.sv | 48 ++++
 tb/tb_ram.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/sap_pkg.sv
// Shared definitions for the 16-bit SAP computer datapath.
// Widths of the system bus, the MAR and main memory.
package sap_pkg;

   localparam int DATA_W    = 16;
   localparam int ADDR_W    = 16;
   localparam int RAM_DEPTH = 16;
   localparam int RAM_AW    = $clog2(RAM_DEPTH);

   typedef logic [DATA_W-1:0] word_t;

   localparam word_t RAM_RESET_VAL = '0;

endpackage

// File: rtl/ram_if.sv
// Memory port of the SAP datapath: bus write data, MAR address,
// write strobe and the continuously driven read word.
interface ram_if;
   import sap_pkg::*;

   word_t             bus;
   logic [ADDR_W-1:0] addr;
   logic              ram_write;
   word_t             ram_out;

   modport master (
      output bus,
      output addr,
      output ram_write,
      input  ram_out
   );

   modport slave (
      input  bus,
      input  addr,
      input  ram_write,
      output ram_out
   );

endinterface

// File: rtl/ram_word_reg.sv
// One memory word: DATA_W flops with load enable and sync reset.
// Reset wins over load.
module ram_word_reg #(
   parameter int                DATA_W    = 16,
   parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_i,
   input  logic [DATA_W-1:0] d_i,
   output logic [DATA_W-1:0] q_o
);

   logic [DATA_W-1:0] q_q;
   logic [DATA_W-1:0] q_d;

   always_comb begin
      q_d = q_q;
      if (load_i) q_d = d_i;
   end

   always_ff @(posedge clk) begin
      if (rst) q_q <= RESET_VAL;
      else     q_q <= q_d;
   end

   assign q_o = q_q;

endmodule

// File: rtl/ram.sv
// SAP main memory: DEPTH flop-based words, synchronous write from
// the bus, combinational read of the word selected by the MAR.
module ram
   import sap_pkg::*;
#(
   parameter int    DEPTH     = RAM_DEPTH,
   parameter word_t RESET_VAL = RAM_RESET_VAL
) (
   input logic  clk,
   input logic  rst,
   ram_if.slave mif
);

   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]     idx;
   logic [DEPTH-1:0]  load;
   word_t             words [DEPTH];
   logic              unused_addr_hi;

   // Only the low AW address bits decode; the rest alias.
   assign idx            = mif.addr[AW-1:0];
   assign unused_addr_hi = ^mif.addr[ADDR_W-1:AW];

   always_comb begin
      load = '0;
      for (int i = 0; i < DEPTH; i++) begin
         load[i] = mif.ram_write && (idx == AW'(i));
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_word
      ram_word_reg #(
         .DATA_W    (DATA_W),
         .RESET_VAL (RESET_VAL)
      ) u_word (
         .clk    (clk),
         .rst    (rst),
         .load_i (load[g]),
         .d_i    (mif.bus),
         .q_o    (words[g])
      );
   end

   // No bus bypass: a write shows up only after the edge.
   assign mif.ram_out = words[idx];

endmodule

// File: tb/tb_ram.sv
// Directed self-checking bench for the SAP main memory.
// Each task drives one scenario and checks ram_out inline.
module tb_ram;
   import sap_pkg::*;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   ram_if u_if ();

   ram dut (
      .clk (clk),
      .rst (rst),
      .mif (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      u_if.ram_write = 1'b0;
      u_if.addr = '0;
      u_if.bus = '0;
      @(negedge clk);
      rst = 1'b0;
      for (int a = 0; a < 16; a++) begin
         u_if.addr = 16'(a);
         #1;
         total++;
         if (u_if.ram_out !== 16'h0000) begin
            bad++;
            $display("FAIL reset_sweep addr=%0d got=%h exp=0000",
                     a, u_if.ram_out);
         end
      end
   endtask

   task automatic test_write();
      @(negedge clk);
      u_if.addr = 16'd2;
      u_if.bus = 16'd9;
      u_if.ram_write = 1'b1;
      #1;
      total++;
      if (u_if.ram_out !== 16'h0000) begin
         bad++;
         $display("FAIL write_pre got=%h exp=0000", u_if.ram_out);
      end
      @(posedge clk);
      #1;
      u_if.ram_write = 1'b0;
      total++;
      if (u_if.ram_out !== 16'h0009) begin
         bad++;
         $display("FAIL write_post got=%h exp=0009", u_if.ram_out);
      end
      for (int a = 0; a < 16; a++) begin
         if (a == 2) continue;
         u_if.addr = 16'(a);
         #1;
         total++;
         if (u_if.ram_out !== 16'h0000) begin
            bad++;
            $display("FAIL write_others addr=%0d got=%h exp=0000",
                     a, u_if.ram_out);
         end
      end
   endtask

   task automatic test_comb_read();
      @(negedge clk);
      u_if.addr = 16'd2;
      #1;
      total++;
      if (u_if.ram_out !== 16'h0009) begin
         bad++;
         $display("FAIL comb_a2 got=%h exp=0009", u_if.ram_out);
      end
      u_if.addr = 16'd3;
      #1;
      total++;
      if (u_if.ram_out !== 16'h0000) begin
         bad++;
         $display("FAIL comb_a3 got=%h exp=0000", u_if.ram_out);
      end
      u_if.addr = 16'd2;
      #1;
      total++;
      if (u_if.ram_out !== 16'h0009) begin
         bad++;
         $display("FAIL comb_a2_again got=%h exp=0009", u_if.ram_out);
      end
   endtask

   task automatic test_alias();
      @(negedge clk);
      u_if.addr = 16'h0012;
      u_if.bus = 16'hABCD;
      u_if.ram_write = 1'b1;
      @(negedge clk);
      u_if.addr = 16'hFFFF;
      u_if.bus = 16'h5A5A;
      @(negedge clk);
      u_if.ram_write = 1'b0;
      u_if.addr = 16'h0002;
      #1;
      total++;
      if (u_if.ram_out !== 16'hABCD) begin
         bad++;
         $display("FAIL alias_a2 got=%h exp=abcd", u_if.ram_out);
      end
      u_if.addr = 16'hFFF2;
      #1;
      total++;
      if (u_if.ram_out !== 16'hABCD) begin
         bad++;
         $display("FAIL alias_fff2 got=%h exp=abcd", u_if.ram_out);
      end
      u_if.addr = 16'h000F;
      #1;
      total++;
      if (u_if.ram_out !== 16'h5A5A) begin
         bad++;
         $display("FAIL alias_a15 got=%h exp=5a5a", u_if.ram_out);
      end
      u_if.addr = 16'h0003;
      #1;
      total++;
      if (u_if.ram_out !== 16'h0000) begin
         bad++;
         $display("FAIL alias_a3 got=%h exp=0000", u_if.ram_out);
      end
   endtask

   task automatic test_reset_priority();
      @(negedge clk);
      rst = 1'b1;
      u_if.ram_write = 1'b1;
      u_if.addr = 16'd5;
      u_if.bus = 16'h1234;
      @(negedge clk);
      rst = 1'b0;
      u_if.ram_write = 1'b0;
      for (int a = 0; a < 16; a++) begin
         u_if.addr = 16'(a);
         #1;
         total++;
         if (u_if.ram_out !== 16'h0000) begin
            bad++;
            $display("FAIL rst_prio addr=%0d got=%h exp=0000",
                     a, u_if.ram_out);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] wa [3];
      logic [15:0] wd [3];
      logic [15:0] old [3];
      wa  = '{16'd0, 16'd1, 16'd0};
      wd  = '{16'h1111, 16'h2222, 16'h3333};
      old = '{16'h0000, 16'h0000, 16'h1111};
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         u_if.addr = wa[i];
         u_if.bus = wd[i];
         u_if.ram_write = 1'b1;
         #1;
         total++;
         if (u_if.ram_out !== old[i]) begin
            bad++;
            $display("FAIL b2b_pre%0d got=%h exp=%h",
                     i, u_if.ram_out, old[i]);
         end
         @(posedge clk);
         #1;
      end
      u_if.ram_write = 1'b0;
      u_if.addr = 16'd0;
      #1;
      total++;
      if (u_if.ram_out !== 16'h3333) begin
         bad++;
         $display("FAIL b2b_w0 got=%h exp=3333", u_if.ram_out);
      end
      u_if.addr = 16'd1;
      #1;
      total++;
      if (u_if.ram_out !== 16'h2222) begin
         bad++;
         $display("FAIL b2b_w1 got=%h exp=2222", u_if.ram_out);
      end
      @(posedge clk);
      #1;
      total++;
      if (u_if.ram_out !== 16'h2222) begin
         bad++;
         $display("FAIL b2b_hold got=%h exp=2222", u_if.ram_out);
      end
   endtask

   initial begin
      total = 0;
      bad = 0;
      rst = 1'b0;
      u_if.ram_write = 1'b0;
      u_if.addr = '0;
      u_if.bus = '0;
      test_reset();
      test_write();
      test_comb_read();
      test_alias();
      test_reset_priority();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
